// File: rtl/demux1to8_buf.sv
// rtl/demux1to8_buf.sv - 1-to-8 demultiplexer with a one-entry holding register per channel
module demux1to8_buf #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [3:0]         busy_count
);

  logic [7:0]       valid_q;
  logic [7:0]       valid_d;
  logic [7:0]       push;
  logic [7:0]       pop;
  logic [WIDTH-1:0] data_q [8];
  logic             accept;
  logic [3:0]       count_d;

  // Input handshake; a full channel still accepts when its consumer pops in the same cycle
  always_comb begin
    in_ready = ~reset & ~flush & (~valid_q[in_sel] | out_ready[in_sel]);
    accept   = in_valid & in_ready;
  end

  // Per-channel push/pop decode and next occupancy (flush > push > pop > hold)
  always_comb begin
    push    = '0;
    pop     = '0;
    valid_d = valid_q;
    count_d = '0;
    for (int i = 0; i < 8; i++) begin
      pop[i]  = valid_q[i] & out_ready[i];
      push[i] = accept & (in_sel == 3'(i));
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (push[i]) begin
        valid_d[i] = 1'b1;
      end else if (pop[i]) begin
        valid_d[i] = 1'b0;
      end
      count_d = count_d + {3'b000, valid_d[i]};
    end
  end

  // Channel state; busy_count is registered from the next occupancy so it tracks out_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      busy_count <= '0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      busy_count <= count_d;
      for (int i = 0; i < 8; i++) begin
        if (push[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  // Outputs come straight from the holding registers
  always_comb begin
    out_valid = valid_q;
    out_data  = '0;
    for (int i = 0; i < 8; i++) begin
      out_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

endmodule

// File: tb/tb_demux1to8_buf.sv
// tb/tb_demux1to8_buf.sv - self-checking bench for demux1to8_buf
module tb_demux1to8_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [255:0] out_data;
  logic [3:0]  busy_count;

  int total = 0;
  int bad   = 0;

  // model: one FIFO of pending words per channel
  logic [31:0] mq [8][$];
  logic        exp_acc   = 1'b0;
  logic        count_on  = 1'b0;
  int          acc_cnt   = 0;
  int          pop_cnt   = 0;

  demux1to8_buf #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_ready();
    return !flush && (mq[in_sel].size() == 0 || out_ready[in_sel]);
  endfunction

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [3:0] model_busy();
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += mq[i].size();
    return 4'(s);
  endfunction

  // model state update at each clock edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (flush) mq[i].delete();
        else if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
      end
      if (exp_acc) begin
        mq[in_sel].push_back(in_data);
        if (count_on) acc_cnt <= acc_cnt + 1;
      end
    end
  end

  // compare process: every cycle out of reset, mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_acc <= 1'b0;
    end else begin
      exp_acc <= in_valid && model_ready();
      chk("cyc_in_ready", in_ready, model_ready());
      chk("cyc_out_valid", out_valid, model_valid());
      chk("cyc_busy_count", busy_count, model_busy());
      for (int i = 0; i < 8; i++) begin
        if (mq[i].size() != 0) chk($sformatf("cyc_out_data%0d", i), out_data[i*32 +: 32], mq[i][0]);
      end
      if (count_on) pop_cnt <= pop_cnt + $countones(out_valid & out_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h55; out_ready = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_busy", busy_count, 4'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0; reset = 1'b0; #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // single word to channel 3, then a blocked second word
    tick();
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hDEADBEEF;
    tick();
    in_data = 32'hCAFEF00D; #1;
    chk("t2_out_valid", out_valid, 8'h08);
    chk("t2_ch3", out_data[3*32 +: 32], 32'hDEADBEEF);
    chk("t2_busy", busy_count, 4'd1);
    chk("t2_in_ready", in_ready, 1'b0);
    tick();
    chk("t2_ch3_hold", out_data[3*32 +: 32], 32'hDEADBEEF);

    // pass-through refill on channel 3
    out_ready = 8'h08; in_data = 32'h1234; #1;
    chk("t3_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 8'h00; #1;
    chk("t3_ch3", out_data[3*32 +: 32], 32'h1234);
    chk("t3_out_valid", out_valid, 8'h08);
    chk("t3_busy", busy_count, 4'd1);

    // drain, then fill all eight channels
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00; #1;
    chk("t4_empty", out_valid, 8'h00);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_data = i * 32'h1111;
      tick();
    end
    in_valid = 1'b0; #1;
    chk("t4_full_valid", out_valid, 8'hFF);
    chk("t4_full_busy", busy_count, 4'd8);
    chk("t4_ch1", out_data[1*32 +: 32], 32'h1111);
    chk("t4_ch7", out_data[7*32 +: 32], 32'h7777);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s); #1;
      chk($sformatf("t4_full_ready%0d", s), in_ready, 1'b0);
    end
    out_ready = 8'hA5;
    tick();
    out_ready = 8'h00; #1;
    chk("t4_pop_valid", out_valid, 8'h5A);
    chk("t4_pop_busy", busy_count, 4'd4);
    chk("t4_ch6", out_data[6*32 +: 32], 32'h6666);

    // flush beats a simultaneous push
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00; in_valid = 1'b1; in_sel = 3'd0; in_data = 32'hA0;
    tick();
    in_sel = 3'd5; in_data = 32'hA5;
    tick();
    in_valid = 1'b0; #1;
    chk("t5_pre_valid", out_valid, 8'h21);
    chk("t5_pre_busy", busy_count, 4'd2);
    flush = 1'b1; in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hBB; #1;
    chk("t5_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("t5_valid", out_valid, 8'h00);
    chk("t5_busy", busy_count, 4'd0);

    // reset mid-transfer drops pending words immediately
    in_valid = 1'b1; in_sel = 3'd4; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    chk("t6_pre_valid", out_valid, 8'h10);
    reset = 1'b1; #1;
    chk("t6_rst_valid", out_valid, 8'h00);
    chk("t6_rst_busy", busy_count, 4'd0);
    chk("t6_rst_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0; #1;
    chk("t6_rel_ready", in_ready, 1'b1);

    // random traffic against the per-channel FIFO model
    tick();
    count_on = 1'b1;
    repeat (10000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = 8'($urandom);
      tick();
    end
    count_on = 1'b0; in_valid = 1'b0; out_ready = 8'h00; #1;
    chk("rand_activity", acc_cnt > 1000, 1'b1);
    chk("rand_no_loss", pop_cnt + busy_count, acc_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
